// File: rtl/dmem_axil_master.sv
// CPU data-memory port to AXI-Lite master bridge: one outstanding access,
// the CPU is stalled until the bus completes and the result shows in DONE.
module dmem_axil_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        sel,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              stall,
  output logic              err,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-3:0]   addr_q;
  logic [3:0]          sel_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                arvalid_q, arvalid_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                err_q, err_d;
  logic                latch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      err_q     <= err_d;
      // Request fields are captured only in IDLE, so they stay frozen while any valid is up.
      if (latch) begin
        addr_q  <= addr[ADDR_W-1:2];
        sel_q   <= sel;
        wdata_q <= data_i;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    err_d     = err_q;
    latch     = 1'b0;
    stall     = 1'b0;
    rready    = 1'b0;
    bready    = 1'b0;
    case (state_q)
      IDLE: begin
        stall = ce;
        if (ce) begin
          latch = 1'b1;
          err_d = 1'b0;
          if (!write_en) begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end else if (sel != 4'b0000) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_ADDR: begin
        stall = 1'b1;
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        stall  = 1'b1;
        rready = 1'b1;
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = (rresp != 2'b00);
          state_d = DONE;
        end
      end
      WR_REQ: begin
        stall = 1'b1;
        if (awready) awvalid_d = 1'b0;
        if (wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        stall  = 1'b1;
        bready = 1'b1;
        if (bvalid) begin
          err_d   = (bresp != 2'b00);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign err     = (state_q == DONE) && err_q;
  assign data_o  = rdata_q;
  assign araddr  = {addr_q, 2'b00};
  assign awaddr  = {addr_q, 2'b00};
  assign arprot  = 3'b000;
  assign awprot  = 3'b000;
  assign arvalid = arvalid_q;
  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = sel_q;

endmodule

// File: tb/tb_dmem_axil_master.sv
// Directed bench for dmem_axil_master: delay-programmable AXI-Lite slave plus
// a transaction-level model predicting latency, completion flags and read data.
module tb_dmem_axil_master;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, ce, write_en;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        sel;
  logic [31:0]       data_i, data_o;
  logic              stall, err;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;

  dmem_axil_master #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .write_en(write_en), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .stall(stall), .err(err),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int n_vec = 0, n_err = 0;

  // slave programming and observation
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_resp = '0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
  int ar_hi = 0, aw_hi = 0, w_hi = 0;
  logic ar_pend = 0, aw_pend = 0, w_pend = 0;
  logic [31:0] ar_paddr = '0, aw_paddr = '0, w_pdata = '0;
  logic [3:0]  w_pstrb = '0;
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  // model state
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_data_o = '0;
  logic [3:0]  exp_strb = '0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Called once per cycle, mid-cycle: checks channel rules and drives the slave side.
  task automatic slave_step();
    chk1("ar_aw_exclusive", arvalid & (awvalid | wvalid), 1'b0);
    if (ar_pend) begin
      chk1("arvalid_hold", arvalid, 1'b1);
      chk32("araddr_stable", araddr, ar_paddr);
    end
    if (aw_pend) begin
      chk1("awvalid_hold", awvalid, 1'b1);
      chk32("awaddr_stable", awaddr, aw_paddr);
    end
    if (w_pend) begin
      chk1("wvalid_hold", wvalid, 1'b1);
      chk32("wdata_stable", wdata, w_pdata);
      chk32("wstrb_stable", 32'(wstrb), 32'(w_pstrb));
    end
    if (arvalid) begin
      ar_hi++;
      arready = (ar_cnt == ar_dly);
      if (arready) begin
        ar_hs++; last_araddr = araddr; ar_cnt = 0;
        chk32("araddr", araddr, exp_addr);
        chk32("arprot", 32'(arprot), 32'd0);
      end else ar_cnt++;
    end else begin
      arready = 1'b0; ar_cnt = 0;
    end
    ar_pend = arvalid & ~arready; ar_paddr = araddr;
    if (awvalid) begin
      aw_hi++;
      awready = (aw_cnt == aw_dly);
      if (awready) begin
        aw_hs++; last_awaddr = awaddr; aw_cnt = 0;
        chk32("awaddr", awaddr, exp_addr);
        chk32("awprot", 32'(awprot), 32'd0);
      end else aw_cnt++;
    end else begin
      awready = 1'b0; aw_cnt = 0;
    end
    aw_pend = awvalid & ~awready; aw_paddr = awaddr;
    if (wvalid) begin
      w_hi++;
      wready = (w_cnt == w_dly);
      if (wready) begin
        w_hs++; last_wdata = wdata; last_wstrb = wstrb; w_cnt = 0;
        chk32("wdata", wdata, exp_wdata);
        chk32("wstrb", 32'(wstrb), 32'(exp_strb));
      end else w_cnt++;
    end else begin
      wready = 1'b0; w_cnt = 0;
    end
    w_pend = wvalid & ~wready; w_pdata = wdata; w_pstrb = wstrb;
    if (rready) begin
      rvalid = (r_cnt == r_dly); r_cnt++;
    end else begin
      rvalid = 1'b0; r_cnt = 0;
    end
    if (rvalid) begin
      r_hs++; rdata = s_rdata; rresp = s_resp;
    end else begin
      rdata = 32'h0BAD0BAD; rresp = 2'b11;
    end
    if (bready) begin
      bvalid = (b_cnt == b_dly); b_cnt++;
    end else begin
      bvalid = 1'b0; b_cnt = 0;
    end
    if (bvalid) begin
      b_hs++; bresp = s_resp;
    end else bresp = 2'b11;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ce = 1'b0; write_en = 1'b0; addr = '0; sel = '0; data_i = '0;
      #1;
      slave_step();
      chk1("stall_idle", stall, 1'b0);
      chk1("err_idle", err, 1'b0);
      chk32("data_o_idle", data_o, exp_data_o);
    end
  endtask

  // Issues one request and follows it to its DONE cycle; ends inside DONE with ce still held.
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input int ard, input int rd, input int awd,
                         input int wd, input int bd, input logic [31:0] rdat,
                         input logic [1:0] resp);
    int lat;
    int ar0, r0, aw0, w0, b0;
    logic exp_err;
    ar0 = ar_hs; r0 = r_hs; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    ar_dly = ard; r_dly = rd; aw_dly = awd; w_dly = wd; b_dly = bd;
    s_rdata = rdat; s_resp = resp;
    exp_addr = {a[31:2], 2'b00}; exp_wdata = d; exp_strb = s;
    if (!we) lat = 3 + ard + rd;
    else if (s != 4'b0000) lat = 3 + ((awd > wd) ? awd : wd) + bd;
    else lat = 1;
    exp_err = (lat == 1) ? 1'b0 : (resp != 2'b00);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c == 0) begin
        ce = 1'b1; write_en = we; addr = a; sel = s; data_i = d;
      end
      #1;
      slave_step();
      chk1("stall", stall, (c < lat));
      if (c < lat) chk1("err_busy", err, 1'b0);
      else begin
        if (!we) exp_data_o = rdat;
        chk1("err_done", err, exp_err);
      end
      chk32("data_o", data_o, exp_data_o);
    end
    chk32("ar_count", 32'(ar_hs - ar0), we ? 32'd0 : 32'd1);
    chk32("r_count", 32'(r_hs - r0), we ? 32'd0 : 32'd1);
    chk32("aw_count", 32'(aw_hs - aw0), (we && s != 0) ? 32'd1 : 32'd0);
    chk32("w_count", 32'(w_hs - w0), (we && s != 0) ? 32'd1 : 32'd0);
    chk32("b_count", 32'(b_hs - b0), (we && s != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_awvalid", awvalid, 1'b0);
    chk1("rst_wvalid", wvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_bready", bready, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk32("rst_data_o", data_o, 32'h0);
  endtask

  initial begin
    int h0, h1, h2;
    rst = 1'b1; ce = 1'b0; write_en = 1'b0; addr = '0; sel = '0; data_i = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs();
    chk1("rst_stall_ce0", stall, 1'b0);
    ce = 1'b1;
    #1 chk1("rst_stall_ce1", stall, 1'b1);
    @(negedge clk); #1;
    chk_reset_outputs();
    chk1("rst_stall_held", stall, 1'b1);
    ce = 1'b0;
    rst = 1'b0;
    idle(2);

    // plain read, everything immediate
    run_txn(1'b0, 32'h1004, 4'hF, 32'h0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00);
    chk32("lit_read_data", data_o, 32'hDEADBEEF);
    chk32("lit_araddr", last_araddr, 32'h0000_1004);
    idle(1);

    // write, wready two cycles after awready, b one cycle late
    h0 = aw_hi; h1 = w_hi;
    run_txn(1'b1, 32'h2003, 4'b0110, 32'h11223344, 0, 0, 0, 2, 1, 32'h0, 2'b00);
    chk32("lit_awaddr", last_awaddr, 32'h0000_2000);
    chk32("lit_wstrb", 32'(last_wstrb), 32'h6);
    chk32("lit_wdata", last_wdata, 32'h11223344);
    chk32("lit_aw_cycles", 32'(aw_hi - h0), 32'd1);
    chk32("lit_w_cycles", 32'(w_hi - h1), 32'd3);
    chk32("lit_data_o_after_wr", data_o, 32'hDEADBEEF);
    idle(1);

    // read, arready five cycles late, SLVERR
    h2 = ar_hi;
    run_txn(1'b0, 32'h300A, 4'hF, 32'h0, 5, 1, 0, 0, 0, 32'hCAFEF00D, 2'b10);
    chk32("lit_ar_cycles", 32'(ar_hi - h2), 32'd6);
    chk1("lit_err_slverr", err, 1'b1);
    chk32("lit_err_data", data_o, 32'hCAFEF00D);
    idle(1);

    // write with no lanes: no bus traffic, done next cycle
    run_txn(1'b1, 32'h4000, 4'b0000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 32'h0, 2'b10);
    chk32("lit_sel0_data", data_o, 32'hCAFEF00D);
    idle(1);

    // write with AW late and W early, EXOKAY counts as non-OKAY
    run_txn(1'b1, 32'h5554, 4'b1001, 32'hA5A55A5A, 0, 0, 3, 0, 2, 32'h0, 2'b01);
    idle(1);

    // back-to-back: read, write, read, CPU advancing in each DONE cycle
    run_txn(1'b0, 32'h6000, 4'hF, 32'h0, 1, 2, 0, 0, 0, 32'h01234567, 2'b00);
    run_txn(1'b1, 32'h6004, 4'b1111, 32'h89ABCDEF, 0, 0, 1, 1, 0, 32'h0, 2'b00);
    run_txn(1'b0, 32'h6008, 4'hF, 32'h0, 0, 0, 0, 0, 0, 32'h76543210, 2'b00);
    chk32("lit_b2b_data", data_o, 32'h76543210);
    idle(2);

    // reset pulse while waiting in RD_DATA
    ar_dly = 0; r_dly = 20; exp_addr = 32'h7000;
    @(negedge clk);
    ce = 1'b1; write_en = 1'b0; addr = 32'h7000; sel = 4'hF;
    #1 slave_step();
    @(negedge clk); #1 slave_step();
    @(negedge clk); #1 slave_step();
    chk1("rd_data_rready", rready, 1'b1);
    @(negedge clk);
    rst = 1'b1; ce = 1'b0;
    #1 slave_step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_data_o = 32'h0;
    chk_reset_outputs();
    chk1("rst_mid_stall", stall, 1'b0);
    slave_step();
    idle(2);
    run_txn(1'b0, 32'h8010, 4'hF, 32'h0, 0, 0, 0, 0, 0, 32'h55AA55AA, 2'b00);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_axil_master.md
DMEM_AXIL_MASTER -- requirements
Module: dmem_axil_master

Interface
REQ-001 Parameter: ADDR_W, 32, width of the CPU address and the AXI-Lite address buses.
REQ-002 clk  in  1  single clock; all logic on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ce  in  1  CPU data-memory request; held stable by the CPU while stall=1.
REQ-005 write_en  in  1  1=write, 0=read.
REQ-006 addr  in  ADDR_W  byte address; bits [1:0] ignored.
REQ-007 sel  in  4  byte lanes; sel[i] maps to data bits [8i+7:8i].
REQ-008 data_i  in  32  write data.
REQ-009 data_o  out  32  read data, valid in the completion cycle.
REQ-010 stall  out  1  CPU must hold its request while this is 1.
REQ-011 err  out  1  completion carried a non-OKAY response.
REQ-012 AXI-Lite write channels: awaddr out ADDR_W, awprot out 3, awvalid out 1, awready in 1; wdata out 32, wstrb out 4, wvalid out 1, wready in 1; bresp in 2, bvalid in 1, bready out 1.
REQ-013 AXI-Lite read channels: araddr out ADDR_W, arprot out 3, arvalid out 1, arready in 1; rdata in 32, rresp in 2, rvalid in 1, rready out 1.

Function
REQ-014 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP and DONE.
REQ-015 IDLE with ce=1: latch addr/sel/data_i/write_en, then go to RD_ADDR (read), WR_REQ (write with sel!=0) or DONE (write with sel=0, no bus traffic, err=0).
REQ-016 stall = (state==IDLE && ce) || state in {RD_ADDR, RD_DATA, WR_REQ, WR_RESP}; it SHALL be combinational and 0 in IDLE with ce=0 and in DONE.
REQ-017 araddr/awaddr = {latched addr[ADDR_W-1:2], 2'b00}; arprot = awprot = 3'b000.
REQ-018 RD_ADDR: arvalid=1 (registered, asserted from the first RD_ADDR cycle); on arvalid&&arready go to RD_DATA and drop arvalid.
REQ-019 RD_DATA: rready=1; on rvalid capture rdata into the data_o register, err_next=(rresp!=2'b00), go to DONE.
REQ-020 WR_REQ: awvalid=wvalid=1 on entry; wdata = latched data_i, wstrb = latched sel; each valid drops independently after its own handshake; leave for WR_RESP once both handshakes have completed (same or different cycles).
REQ-021 WR_RESP: bready=1; on bvalid, err_next=(bresp!=2'b00), go to DONE.
REQ-022 No valid SHALL deassert before its handshake, and the latched address, data and strobe SHALL NOT change while any valid is high.
REQ-023 DONE lasts exactly one cycle: stall=0, err=captured flag, data_o=captured read data; next state IDLE unconditionally, so the request held in that cycle is not reissued.
REQ-024 err SHALL be 0 in every state except DONE.
REQ-025 data_o SHALL hold its last captured value outside read completion; writes SHALL NOT modify it.
REQ-026 Minimum latency, all readies and responses immediate: ce seen in cycle 0, DONE in cycle 3 (stall high for cycles 0-2).
REQ-027 One outstanding transaction maximum; the AR and AW/W channels are never active at the same time.

Reset
REQ-028 While rst=1: state=IDLE, all valid/ready outputs 0, data_o=0, err=0, latches=0; stall still follows REQ-016 (1 only when ce=1).
REQ-029 rst asserted mid-transaction SHALL abort immediately to IDLE; interconnect reset is the system's responsibility.

Verification
REQ-030 Read, all ready: addr=0x1004, rdata=0xDEADBEEF, rresp=0 -> araddr=0x1004, stall high for 3 cycles, DONE cycle data_o=0xDEADBEEF, err=0.
REQ-031 Write, wready 2 cycles after awready: addr=0x2003, sel=4'b0110, data_i=0x11223344 -> awaddr=0x2000, wstrb=0110, wdata=0x11223344; awvalid drops first, wvalid is held until wready; completes after bvalid.
REQ-032 Read with arready delayed 5 cycles and rresp=2'b10 -> arvalid stays high 6 cycles, DONE with err=1 and data_o=rdata.
REQ-033 Write with sel=0 -> no AW/W/B activity, DONE in cycle 1, err=0, data_o unchanged.
REQ-034 Back-to-back read then write with the CPU advancing in the DONE cycle -> the second transaction starts in the following IDLE cycle, no duplicate issue.
REQ-035 rst pulse while in RD_DATA -> next cycle all outputs at reset values and state IDLE.
